// File: rtl/axi_xbar_pkg.sv
// ---------------------------------------------------------------------------
// axi_xbar_pkg
// Shared definitions for the AXI crossbar response-channel arbiters.
//   - RRESP/BRESP encodings
//   - AXI3 burst length limit
//   - R-channel payload struct and arbiter state encoding
// No ports (package).
// ---------------------------------------------------------------------------
package axi_xbar_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // ARLEN is 4 bits in AXI3, so a burst carries at most 16 beats.
    localparam int AXI3_MAX_BEATS = 16;

    localparam int R_ID_W   = 4;
    localparam int R_DATA_W = 32;

    typedef struct packed {
        logic [R_ID_W-1:0]   id;
        logic [R_DATA_W-1:0] data;
        logic [1:0]          resp;
        logic                last;
    } r_chan_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_prio_sel.sv
// ---------------------------------------------------------------------------
// rr_prio_sel
// Combinational round-robin first-one finder. Scans req_i starting at
// ptr_i, wrapping at N (N need not be a power of two), and returns the
// first asserted index.
//   req_i   in  N   request vector
//   ptr_i   in  IW  scan start position (highest priority)
//   idx_o   out IW  first asserted index at or after ptr_i (0 if none)
//   found_o out 1   any request asserted
// ---------------------------------------------------------------------------
module rr_prio_sel #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    // Position k steps after p, wrapped explicitly at N.
    function automatic logic [IW-1:0] slot(logic [IW-1:0] p, int k);
        int s;
        s = int'(p) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan from the farthest slot back to ptr_i so the nearest hit wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[slot(ptr_i, k)]) begin
                idx_o   = slot(ptr_i, k);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_r_arbiter.sv
// ---------------------------------------------------------------------------
// axi_r_arbiter
// Shares one master-side AXI R channel among NUM_SLV slave R channels.
// Round-robin at burst granularity: the grant locks from the first beat
// (or first stalled presentation) until the RLAST handshake. Datapath is
// a zero-latency combinational mux; arbitration state is registered.
// Flags bursts longer than MAX_BEATS with a sticky error.
//   aclk, aresetn           clock, async active-low reset
//   s_rvalid/s_rready       per-slave handshake
//   s_rid/s_rdata/s_rresp   packed per-slave payload, slave i at [i*W +: W]
//   s_rlast                 per-slave RLAST
//   m_r*                    master-side R channel
//   m_rsrc                  index of the slave driving the master side
//   busy                    a burst is locked
//   err_overrun             sticky burst-length violation
// ---------------------------------------------------------------------------
module axi_r_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int NUM_SLV    = 4,
    parameter int AXI_ID_W   = 4,
    parameter int AXI_DATA_W = 32,
    parameter int MAX_BEATS  = AXI3_MAX_BEATS
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NUM_SLV-1:0]             s_rvalid,
    output logic [NUM_SLV-1:0]             s_rready,
    input  logic [NUM_SLV*AXI_ID_W-1:0]    s_rid,
    input  logic [NUM_SLV*AXI_DATA_W-1:0]  s_rdata,
    input  logic [NUM_SLV*2-1:0]           s_rresp,
    input  logic [NUM_SLV-1:0]             s_rlast,
    output logic                           m_rvalid,
    input  logic                           m_rready,
    output logic [AXI_ID_W-1:0]            m_rid,
    output logic [AXI_DATA_W-1:0]          m_rdata,
    output logic [1:0]                     m_rresp,
    output logic                           m_rlast,
    output logic [$clog2(NUM_SLV)-1:0]     m_rsrc,
    output logic                           busy,
    output logic                           err_overrun
);

    localparam int IW = $clog2(NUM_SLV);
    localparam int CW = $clog2(MAX_BEATS + 1);

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   lock_idx_q, lock_idx_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            err_q, err_d;

    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic [IW-1:0]   sel;
    logic            arb_vld;
    logic            hs;

    function automatic logic [IW-1:0] ptr_inc(logic [IW-1:0] p);
        if (p == IW'(NUM_SLV - 1)) return '0;
        return p + 1'b1;
    endfunction

    rr_prio_sel #(
        .N  (NUM_SLV),
        .IW (IW)
    ) u_rr_sel (
        .req_i   (s_rvalid),
        .ptr_i   (rr_ptr_q),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        hs         = m_rvalid & m_rready;

        // A non-last handshake on the MAX_BEATS-th beat means the burst overran.
        if (hs && !m_rlast && beat_cnt_q == CW'(MAX_BEATS - 1))
            err_d = 1'b1;

        case (state_q)
            ARB_IDLE: begin
                if (win_found) begin
                    if (hs && m_rlast) begin
                        rr_ptr_d   = ptr_inc(win_idx);
                        beat_cnt_d = '0;
                    end else begin
                        // Lock even on a stalled first beat so the grant
                        // cannot move while the master holds off.
                        state_d    = ARB_BURST;
                        lock_idx_d = win_idx;
                        beat_cnt_d = hs ? CW'(1) : '0;
                    end
                end
            end
            ARB_BURST: begin
                if (hs) begin
                    if (m_rlast) begin
                        state_d    = ARB_IDLE;
                        rr_ptr_d   = ptr_inc(lock_idx_q);
                        beat_cnt_d = '0;
                    end else if (beat_cnt_q != CW'(MAX_BEATS)) begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Output logic: grant select and combinational datapath mux
    always_comb begin
        sel      = (state_q == ARB_BURST) ? lock_idx_q : win_idx;
        arb_vld  = (state_q == ARB_BURST) | win_found;
        m_rvalid = 1'b0;
        m_rid    = '0;
        m_rdata  = '0;
        m_rresp  = '0;
        m_rlast  = 1'b0;
        s_rready = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (IW'(i) == sel) begin
                m_rvalid    = s_rvalid[i];
                m_rid       = s_rid[i*AXI_ID_W +: AXI_ID_W];
                m_rdata     = s_rdata[i*AXI_DATA_W +: AXI_DATA_W];
                m_rresp     = s_rresp[i*2 +: 2];
                m_rlast     = s_rlast[i];
                s_rready[i] = m_rready & arb_vld;
            end
        end
    end

    assign m_rsrc      = sel;
    assign busy        = (state_q == ARB_BURST);
    assign err_overrun = err_q;

endmodule

// File: tb/tb_axi_r_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_r_arbiter
// Directed bench for axi_r_arbiter. Slave BFMs replay per-slave beat queues;
// expected master-side beats are queued in hand-derived arbitration order
// and a monitor compares every master handshake against that queue.
// ---------------------------------------------------------------------------
module tb_axi_r_arbiter;
    import axi_xbar_pkg::*;

    localparam int NS  = 4;
    localparam int IDW = 4;
    localparam int DW  = 32;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NS-1:0]     s_rvalid, s_rready, s_rlast;
    logic [NS*IDW-1:0] s_rid;
    logic [NS*DW-1:0]  s_rdata;
    logic [NS*2-1:0]   s_rresp;
    logic              m_rvalid, m_rready, m_rlast;
    logic [IDW-1:0]    m_rid;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic [1:0]        m_rsrc;
    logic              busy, err_overrun;

    axi_r_arbiter #(
        .NUM_SLV(NS), .AXI_ID_W(IDW), .AXI_DATA_W(DW), .MAX_BEATS(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rsrc(m_rsrc), .busy(busy), .err_overrun(err_overrun)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [1:0] src;
        r_chan_t    b;
    } exp_t;

    r_chan_t       sq [NS][$];
    exp_t          exp_q[$];
    logic [NS-1:0] hold;
    logic [NS-1:0] pop_f;
    int            nchk;
    int            nerr;

    function automatic r_chan_t mk_beat(logic [3:0] id, logic [31:0] base, int k, int n);
        r_chan_t b;
        b.id   = id;
        b.data = base + 32'(k);
        b.resp = 2'(k % 4);
        b.last = (k == n);
        return b;
    endfunction

    task automatic push_slv(int s, logic [3:0] id, logic [31:0] base, int n);
        for (int k = 1; k <= n; k++) sq[s].push_back(mk_beat(id, base, k, n));
    endtask

    task automatic push_exp(int s, logic [3:0] id, logic [31:0] base, int n);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            e.src = 2'(s);
            e.b   = mk_beat(id, base, k, n);
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_slaves();
        for (int i = 0; i < NS; i++) begin
            if (sq[i].size() > 0 && !hold[i]) begin
                s_rvalid[i]             = 1'b1;
                s_rid[i*IDW +: IDW]     = sq[i][0].id;
                s_rdata[i*DW +: DW]     = sq[i][0].data;
                s_rresp[i*2 +: 2]       = sq[i][0].resp;
                s_rlast[i]              = sq[i][0].last;
            end else begin
                s_rvalid[i]             = 1'b0;
                s_rid[i*IDW +: IDW]     = '0;
                s_rdata[i*DW +: DW]     = '0;
                s_rresp[i*2 +: 2]       = '0;
                s_rlast[i]              = 1'b0;
            end
        end
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
        nchk++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    // Compares every master-side handshake against the expected queue.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge aclk);
            for (int i = 0; i < NS; i++) pop_f[i] = s_rvalid[i] & s_rready[i];
            if (aresetn && m_rvalid && m_rready) begin
                if (exp_q.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL beat_unexpected: got src=%0d data=%0h want none", m_rsrc, m_rdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {m_rsrc, m_rid, m_rdata, m_rresp, m_rlast}, e);
                end
            end
        end
    endtask

    // Slave side: retire handshaken beats, present the next one.
    task automatic bfm();
        forever begin
            @(posedge aclk);
            #1;
            for (int i = 0; i < NS; i++)
                if (pop_f[i] && sq[i].size() > 0) sq[i].delete(0);
            drive_slaves();
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #2;
    endtask

    task automatic wait_drain(string nm, int maxc);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < maxc) begin
            step();
            c++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        nchk = 0; nerr = 0;
        hold = '0; pop_f = '0; m_rready = 1'b0;
        s_rvalid = '0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0;
        aresetn = 1'b0;
        fork
            monitor();
            bfm();
        join_none
        drive_slaves();
        repeat (2) @(posedge aclk);
        #2;
        chk("rst_m_rvalid", m_rvalid, 0);
        chk("rst_s_rready", s_rready, 0);
        chk("rst_m_rsrc", m_rsrc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_overrun, 0);
        aresetn  = 1'b1;
        m_rready = 1'b1;
        step();

        // Single requester: 4 beats back to back from slave 2.
        push_slv(2, 4'h5, 32'h2000_0000, 4);
        push_exp(2, 4'h5, 32'h2000_0000, 4);
        drive_slaves();
        #1;
        chk("t1_src", m_rsrc, 2);
        repeat (4) step();
        chk("t1_consecutive", exp_q.size(), 0);
        chk("t1_idle", busy, 0);

        // rr_ptr is now 3: slave 3 beats slave 0, then 0, then 3 again.
        push_slv(0, 4'h1, 32'h0100_0000, 1);
        push_slv(3, 4'h3, 32'h3100_0000, 1);
        push_slv(3, 4'h3, 32'h3200_0000, 1);
        push_exp(3, 4'h3, 32'h3100_0000, 1);
        push_exp(0, 4'h1, 32'h0100_0000, 1);
        push_exp(3, 4'h3, 32'h3200_0000, 1);
        drive_slaves();
        wait_drain("t1b_rr_order", 20);

        // All slaves request 2-beat bursts continuously: 0,1,2,3,0,1,2,3.
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NS; s++)
                push_slv(s, 4'(8 + s), 32'h5000_0000 + 32'(s * 256 + r * 16), 2);
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NS; s++)
                push_exp(s, 4'(8 + s), 32'h5000_0000 + 32'(s * 256 + r * 16), 2);
        drive_slaves();
        repeat (16) step();
        chk("t2_no_bubble", exp_q.size(), 0);

        // Lock: slave 1 pauses mid-burst while slave 0 waits.
        push_slv(1, 4'h6, 32'h1100_0000, 4);
        push_exp(1, 4'h6, 32'h1100_0000, 4);
        drive_slaves();
        step();
        step();
        hold[1] = 1'b1;
        push_slv(0, 4'h7, 32'h0700_0000, 2);
        push_exp(0, 4'h7, 32'h0700_0000, 2);
        drive_slaves();
        #1;
        chk("t3_busy", busy, 1);
        for (int g = 0; g < 3; g++) begin
            chk("t3_gap_src", m_rsrc, 1);
            chk("t3_gap_vld", m_rvalid, 0);
            chk("t3_gap_rdy0", s_rready[0], 0);
            if (g < 2) step();
        end
        hold[1] = 1'b0;
        drive_slaves();
        wait_drain("t3_drain", 30);

        // Bring rr_ptr to 3.
        push_slv(2, 4'h2, 32'h2200_0000, 1);
        push_exp(2, 4'h2, 32'h2200_0000, 1);
        drive_slaves();
        wait_drain("t4_pre", 10);

        // Backpressure on the first beat: grant must stay on slave 3.
        m_rready = 1'b0;
        push_slv(3, 4'h9, 32'h3900_0000, 2);
        push_slv(0, 4'hA, 32'h0A00_0000, 1);
        drive_slaves();
        #1;
        for (int g = 0; g < 5; g++) begin
            chk("t4_src", m_rsrc, 3);
            chk("t4_vld", m_rvalid, 1);
            chk("t4_rdy", s_rready, 0);
            step();
        end
        chk("t4_busy", busy, 1);
        push_exp(3, 4'h9, 32'h3900_0000, 2);
        push_exp(0, 4'hA, 32'h0A00_0000, 1);
        m_rready = 1'b1;
        wait_drain("t4_drain", 20);

        // Overrun: 17 beats, RLAST only on the 17th.
        push_slv(0, 4'hC, 32'h0C00_0000, 17);
        push_exp(0, 4'hC, 32'h0C00_0000, 17);
        drive_slaves();
        repeat (15) step();
        chk("t5_err_pre", err_overrun, 0);
        step();
        chk("t5_err_set", err_overrun, 1);
        wait_drain("t5_drain", 10);
        chk("t5_err_sticky", err_overrun, 1);
        chk("t5_idle", busy, 0);

        // Bring rr_ptr to 3, then reset during beat 2 of a slave-1 burst.
        push_slv(2, 4'h2, 32'h2300_0000, 1);
        push_exp(2, 4'h2, 32'h2300_0000, 1);
        drive_slaves();
        wait_drain("t6_pre", 10);
        push_slv(1, 4'h4, 32'h1400_0000, 4);
        push_exp(1, 4'h4, 32'h1400_0000, 4);
        drive_slaves();
        step();
        chk("t6_mid_busy", busy, 1);
        aresetn = 1'b0;
        for (int i = 0; i < NS; i++) sq[i].delete();
        exp_q.delete();
        drive_slaves();
        #1;
        chk("t6_rst_vld", m_rvalid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rdy", s_rready, 0);
        chk("t6_rst_src", m_rsrc, 0);
        chk("t6_rst_err", err_overrun, 0);
        step();
        step();
        aresetn = 1'b1;
        step();
        // rr_ptr back at 0: slave 1 ahead of slave 3.
        push_slv(3, 4'hE, 32'h3E00_0000, 2);
        push_slv(1, 4'hD, 32'h1D00_0000, 1);
        push_exp(1, 4'hD, 32'h1D00_0000, 1);
        push_exp(3, 4'hE, 32'h3E00_0000, 2);
        drive_slaves();
        wait_drain("t6_post", 20);
        chk("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
